// File: rtl/geofence_n_pkg.sv
// Shared types, width helpers and parameter range limits for the geofence_n engine.
package geofence_n_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SORT = 3'd2,
        TEST = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int CW_MIN = 4;
    localparam int CW_MAX = 16;
    localparam int NV_MIN = 3;
    localparam int NV_MAX = 16;

    function automatic int cross_w(input int cw);
        return 2 * cw + 3;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sort_len(input int nv);
        return (nv - 2) * (nv - 2);
    endfunction

    function automatic bit params_ok(input int cw, input int nv);
        return (cw >= CW_MIN) && (cw <= CW_MAX) && (nv >= NV_MIN) && (nv <= NV_MAX);
    endfunction

    localparam int CW_DEF = 10;
    localparam int NV_DEF = 6;
    localparam int XW_DEF = cross_w(CW_DEF);
    localparam int IW_DEF = cnt_w(NV_DEF);
    localparam int SW_DEF = cnt_w(sort_len(NV_DEF));

endpackage

// File: rtl/geofence_cross.sv
// Exact 2-D cross product (A-P) x (B-P) on unsigned CW-bit coordinates; purely combinational.
module geofence_cross
    import geofence_n_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0]                p_x_i,
    input  logic [CW-1:0]                p_y_i,
    input  logic [CW-1:0]                a_x_i,
    input  logic [CW-1:0]                a_y_i,
    input  logic [CW-1:0]                b_x_i,
    input  logic [CW-1:0]                b_y_i,
    output logic signed [cross_w(CW)-1:0] cross_o
);

    localparam int XW = cross_w(CW);
    localparam int PW = 2 * CW + 2;

    logic signed [CW:0]   dax, day, dbx, dby;
    logic signed [PW-1:0] m1, m2;

    assign dax = $signed({1'b0, a_x_i}) - $signed({1'b0, p_x_i});
    assign day = $signed({1'b0, a_y_i}) - $signed({1'b0, p_y_i});
    assign dbx = $signed({1'b0, b_x_i}) - $signed({1'b0, p_x_i});
    assign dby = $signed({1'b0, b_y_i}) - $signed({1'b0, p_y_i});

    // Full-width products and difference: nothing can overflow or be truncated.
    assign m1 = PW'(dax) * PW'(dby);
    assign m2 = PW'(day) * PW'(dbx);

    assign cross_o = XW'(m1) - XW'(m2);

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon engine: capture T and NV vertices, angle-sort about V0, test T on every edge.
// Build option GEOFENCE_ON_EDGE_INSIDE_EN: boundary and vertex points count as inside.
module geofence_n
    import geofence_n_pkg::*;
#(
    parameter int CW = 10,
    parameter int NV = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          is_inside,
    output logic          valid
);

    localparam int XW = cross_w(CW);
    localparam int IW = cnt_w(NV);
    localparam int SW = cnt_w(sort_len(NV));

    localparam logic [IW-1:0] LAST_V  = IW'(NV - 1);
    localparam logic [IW-1:0] LAST_J  = IW'(NV - 2);
    localparam logic [IW-1:0] FIRST_J = IW'(1);
    localparam logic [SW-1:0] SORT_TC = SW'(sort_len(NV) - 1);

`ifdef GEOFENCE_ON_EDGE_INSIDE_EN
    localparam bit ON_EDGE_EN = 1'b1;
`else
    localparam bit ON_EDGE_EN = 1'b0;
`endif

    if (!params_ok(CW, NV)) begin : g_param_err
        $error("geofence_n: CW must be 4..16 and NV must be 3..16");
    end

    state_e state_q, state_d;

    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] i_q, i_d;
    logic [SW-1:0] sc_q, sc_d;
    logic          flag_q, flag_d;
    logic          inside_q, inside_d;
    logic          valid_q, valid_d;

    logic [CW-1:0] tx_q, ty_q;
    logic [CW-1:0] vx_q [NV];
    logic [CW-1:0] vy_q [NV];

    logic          ld_t, ld_v, swap;
    logic [IW-1:0] a_idx, b_idx;
    logic [CW-1:0] p_x, p_y;
    logic signed [XW-1:0] cr;
    logic          cr_neg, cr_zero, edge_ok;

    // Single cross unit: SORT compares neighbours about V0, TEST checks T against edge i.
    always_comb begin
        a_idx = j_q;
        b_idx = j_q + 1'b1;
        p_x   = vx_q[0];
        p_y   = vy_q[0];
        if (state_q == TEST) begin
            a_idx = i_q;
            b_idx = (i_q == LAST_V) ? '0 : i_q + 1'b1;
            p_x   = tx_q;
            p_y   = ty_q;
        end
    end

    geofence_cross #(.CW(CW)) u_cross (
        .p_x_i   (p_x),
        .p_y_i   (p_y),
        .a_x_i   (vx_q[a_idx]),
        .a_y_i   (vy_q[a_idx]),
        .b_x_i   (vx_q[b_idx]),
        .b_y_i   (vy_q[b_idx]),
        .cross_o (cr)
    );

    assign cr_neg  = cr[XW-1];
    assign cr_zero = (cr == '0);
    assign edge_ok = !cr_neg && (ON_EDGE_EN || !cr_zero);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        j_d      = j_q;
        i_d      = i_q;
        sc_d     = sc_q;
        flag_d   = flag_q;
        inside_d = inside_q;
        valid_d  = 1'b0;
        in_ready = 1'b0;
        ld_t     = 1'b0;
        ld_v     = 1'b0;
        swap     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_t    = 1'b1;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_v = 1'b1;
                    if (k_q == LAST_V) begin
                        state_d = SORT;
                        j_d     = FIRST_J;
                        sc_d    = SORT_TC;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            SORT: begin
                // Clockwise pair about V0: swap so the list ends up counter-clockwise.
                swap = cr_neg;
                j_d  = (j_q == LAST_J) ? FIRST_J : j_q + 1'b1;
                if (sc_q == '0) begin
                    state_d = TEST;
                    i_d     = '0;
                    flag_d  = 1'b1;
                end else begin
                    sc_d = sc_q - 1'b1;
                end
            end
            TEST: begin
                flag_d = flag_q & edge_ok;
                if (i_q == LAST_V) begin
                    inside_d = flag_q & edge_ok;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            j_q      <= '0;
            i_q      <= '0;
            sc_q     <= '0;
            flag_q   <= 1'b0;
            inside_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            j_q      <= j_d;
            i_q      <= i_d;
            sc_q     <= sc_d;
            flag_q   <= flag_d;
            inside_q <= inside_d;
            valid_q  <= valid_d;
        end
    end

    // Point storage needs no reset: every frame rewrites T and all vertices before use.
    always_ff @(posedge clk) begin
        if (ld_t) begin
            tx_q <= X;
            ty_q <= Y;
        end
        if (ld_v) begin
            vx_q[k_q] <= X;
            vy_q[k_q] <= Y;
        end
        if (swap) begin
            vx_q[a_idx] <= vx_q[b_idx];
            vy_q[a_idx] <= vy_q[b_idx];
            vx_q[b_idx] <= vx_q[a_idx];
            vy_q[b_idx] <= vy_q[a_idx];
        end
    end

    assign is_inside = inside_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_geofence_n.sv
// Bench for geofence_n: NV=4 and NV=6 instances against an order-independent convex-hull model.
module tb_geofence_n;

    localparam int CW = 10;

`ifdef GEOFENCE_ON_EDGE_INSIDE_EN
    localparam bit ON_EDGE = 1'b1;
`else
    localparam bit ON_EDGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          drv_valid;
    logic [CW-1:0] drv_x, drv_y;
    int            sel;

    logic iv4, iv6, rdy4, rdy6, ins4, ins6, vld4, vld6;
    logic rdy, ins, vld;

    always #5 clk = ~clk;

    assign iv4 = drv_valid && (sel == 4);
    assign iv6 = drv_valid && (sel == 6);
    assign rdy = (sel == 6) ? rdy6 : rdy4;
    assign ins = (sel == 6) ? ins6 : ins4;
    assign vld = (sel == 6) ? vld6 : vld4;

    geofence_n #(.CW(CW), .NV(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4),
        .X(drv_x), .Y(drv_y), .is_inside(ins4), .valid(vld4)
    );

    geofence_n #(.CW(CW), .NV(6)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(iv6), .in_ready(rdy6),
        .X(drv_x), .Y(drv_y), .is_inside(ins6), .valid(vld6)
    );

    int errors = 0;
    int checks = 0;
    int vx [16];
    int vy [16];

    function automatic longint cr(longint px, longint py, longint ax, longint ay,
                                  longint bx, longint by);
        return (ax - px) * (by - py) - (ay - py) * (bx - px);
    endfunction

    // a->b is a counter-clockwise hull edge when every other vertex lies strictly to its left.
    function automatic bit hull_edge(int n, int a, int b);
        for (int c = 0; c < n; c++)
            if (c != a && c != b && cr(vx[c], vy[c], vx[a], vy[a], vx[b], vy[b]) <= 0)
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit convex_ok(int n);
        int edges = 0;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++)
                if (a != b && hull_edge(n, a, b)) edges++;
        return edges == n;
    endfunction

    function automatic bit model_inside(int n, int tx, int ty);
        bit res = 1'b1;
        longint e;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++)
                if (a != b && hull_edge(n, a, b)) begin
                    e = cr(tx, ty, vx[a], vy[a], vx[b], vy[b]);
                    if (e < 0 || (!ON_EDGE && e == 0)) res = 1'b0;
                end
        return res;
    endfunction

    task automatic do_reset();
        drv_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_beat(int x, int y, bit gaps);
        int budget = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            drv_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drv_valid = 1'b1;
        drv_x = x[CW-1:0];
        drv_y = y[CW-1:0];
        while (!rdy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready got %0d required 1", rdy);
        end
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic run_frame(string name, int n, int tx, int ty, bit gaps, bit exp);
        int cnt = 0;
        int lat = (n - 2) * (n - 2) + n;
        send_beat(tx, ty, gaps);
        for (int k = 0; k < n; k++) send_beat(vx[k], vy[k], gaps);
        while (!vld && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, lat);
        end
        checks++;
        if (ins !== exp) begin
            errors++;
            $display("FAIL %s is_inside: got %0d required %0d (T=%0d,%0d)", name, ins, exp, tx, ty);
        end
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || ins !== exp) begin
            errors++;
            $display("FAIL %s pulse/hold: valid got %0d required 0, is_inside got %0d required %0d",
                     name, vld, ins, exp);
        end
    endtask

    task automatic load_square();
        vx[0] = 10; vy[0] = 10;
        vx[1] = 0;  vy[1] = 0;
        vx[2] = 0;  vy[2] = 10;
        vx[3] = 10; vy[3] = 0;
    endtask

    task automatic load_hexagon();
        vx[0] = 1000; vy[0] = 750;
        vx[1] = 0;    vy[1] = 250;
        vx[2] = 500;  vy[2] = 0;
        vx[3] = 500;  vy[3] = 1000;
        vx[4] = 1000; vy[4] = 250;
        vx[5] = 0;    vy[5] = 750;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rdy4 !== 1'b1 || rdy6 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0d/%0d required 1/1", rdy4, rdy6);
        end
        checks++;
        if (vld4 !== 1'b0 || vld6 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0d/%0d required 0/0", vld4, vld6);
        end
        checks++;
        if (ins4 !== 1'b0 || ins6 !== 1'b0) begin
            errors++;
            $display("FAIL reset_is_inside: got %0d/%0d required 0/0", ins4, ins6);
        end
    endtask

    task automatic test_square();
        sel = 4;
        load_square();
        run_frame("square_centre", 4, 5, 5, 1'b0, 1'b1);
        run_frame("square_right", 4, 15, 5, 1'b0, 1'b0);
        run_frame("square_vertex", 4, 0, 0, 1'b0, ON_EDGE);
        run_frame("square_on_edge", 4, 10, 5, 1'b1, ON_EDGE);
    endtask

    task automatic test_hexagon();
        sel = 6;
        load_hexagon();
        run_frame("hex_centre", 6, 500, 500, 1'b0, 1'b1);
        run_frame("hex_corner", 6, 50, 50, 1'b1, 1'b0);
    endtask

    task automatic gen_poly(int n);
        real base, ang, r;
        int tries = 0;
        int j, tmp;
        do begin
            base = $urandom_range(0, 359) * 3.14159265 / 180.0;
            r = $urandom_range(150, 480);
            for (int k = 0; k < n; k++) begin
                ang = base + (k + ($itor($urandom_range(0, 40)) - 20.0) / 100.0) * 6.2831853 / n;
                vx[k] = $rtoi(512.0 + r * $cos(ang) + 0.5);
                vy[k] = $rtoi(512.0 + r * $sin(ang) + 0.5);
            end
            tries++;
        end while (!convex_ok(n) && tries < 50);
        if (!convex_ok(n)) begin
            checks++;
            errors++;
            $display("FAIL gen_poly: convex got 0 required 1");
        end
        for (int k = n - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = vx[k]; vx[k] = vx[j]; vx[j] = tmp;
            tmp = vy[k]; vy[k] = vy[j]; vy[j] = tmp;
        end
    endtask

    task automatic test_random();
        int n, tx, ty, v;
        for (int f = 0; f < 30; f++) begin
            n = (f % 2 == 0) ? 4 : 6;
            sel = n;
            gen_poly(n);
            v = $urandom_range(0, n - 1);
            case ($urandom_range(0, 3))
                0: begin tx = $urandom_range(0, 1023); ty = $urandom_range(0, 1023); end
                1: begin tx = $urandom_range(362, 662); ty = $urandom_range(362, 662); end
                2: begin tx = vx[v]; ty = vy[v]; end
                default: begin
                    tx = vx[v] + $urandom_range(0, 40) - 20;
                    ty = vy[v] + $urandom_range(0, 40) - 20;
                end
            endcase
            run_frame("random", n, tx, ty, 1'b1, model_inside(n, tx, ty));
        end
    endtask

    task automatic test_back_to_back();
        int bx [10];
        int by [10];
        bit res [2];
        int idx = 0, nres = 0, stall = 0, cyc = 0;
        bit took;
        sel = 4;
        load_square();
        bx[0] = 5;  by[0] = 5;
        bx[5] = 15; by[5] = 5;
        for (int k = 0; k < 4; k++) begin
            bx[1 + k] = vx[k]; by[1 + k] = vy[k];
            bx[6 + k] = vx[k]; by[6 + k] = vy[k];
        end
        while (nres < 2 && cyc < 200) begin
            if (idx < 10) begin
                drv_valid = 1'b1;
                drv_x = bx[idx][CW-1:0];
                drv_y = by[idx][CW-1:0];
            end else begin
                drv_valid = 1'b0;
            end
            if (vld) begin
                res[nres] = ins;
                nres++;
            end
            if (idx > 0 && idx < 10 && !rdy) stall++;
            took = drv_valid && rdy;
            @(posedge clk);
            if (took) idx++;
            @(negedge clk);
            cyc++;
        end
        drv_valid = 1'b0;
        checks++;
        if (nres !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 2", nres);
        end
        checks++;
        if (idx !== 10) begin
            errors++;
            $display("FAIL b2b_beats: got %0d accepted required 10", idx);
        end
        checks++;
        if (stall !== 9) begin
            errors++;
            $display("FAIL b2b_stall: in_ready low got %0d cycles required 9", stall);
        end
        checks++;
        if (res[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result0: got %0d required 1", res[0]);
        end
        checks++;
        if (res[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result1: got %0d required 0", res[1]);
        end
    endtask

    task automatic test_reset_mid_sort();
        int seen = 0;
        sel = 6;
        load_hexagon();
        send_beat(500, 500, 1'b0);
        for (int k = 0; k < 6; k++) send_beat(vx[k], vy[k], 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rdy6 !== 1'b1 || vld6 !== 1'b0 || ins6 !== 1'b0) begin
            errors++;
            $display("FAIL midsort_reset: ready/valid/inside got %0d/%0d/%0d required 1/0/0",
                     rdy6, vld6, ins6);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (vld6) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midsort_no_valid: got %0d pulses required 0", seen);
        end
        run_frame("after_reset_hex", 6, 500, 500, 1'b0, 1'b1);
        sel = 4;
        load_square();
        run_frame("after_reset_square", 4, 5, 5, 1'b0, 1'b1);
    endtask

    initial begin
        sel = 4;
        drv_valid = 1'b0;
        drv_x = '0;
        drv_y = '0;
        reset = 1'b1;
        test_reset();
        test_square();
        test_hexagon();
        test_random();
        test_back_to_back();
        test_reset_mid_sort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
